calc_sequencer: RTL and testbench

Multi-cycle controller and datapath sequencer for the four-function calculator. It captures two operands and an op select on a start pulse, then runs the selected operation:
- add/sub in a single execute cycle
- multiply as iterative shift-add
- divide as restoring division

It produces the result, status flags and the 2-bit decimal-point indicator used by the display stage.

---
 rtl/calc_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle sequencer for the four-function calculator.
// Add/sub in one execute cycle, shift-add multiply and restoring divide over
// WIDTH cycles each; results and flags are registered on entry to DONE.
module calc_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry,
  output logic             product_ofl,
  output logic             quotient_ofl,
  output logic [1:0]       dp,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_DIV    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;       // multiplicand copy / dividend-quotient shift reg
  logic [WIDTH-1:0]   b_q, b_d;       // addend / multiplier shift reg / divisor
  logic [1:0]         sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // product accumulator
  logic [2*WIDTH-1:0] mc_q, mc_d;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               carry_q, carry_d;
  logic               pofl_q, pofl_d;
  logic               qofl_q, qofl_d;
  logic [1:0]         dp_q, dp_d;

  logic               last;
  logic [WIDTH:0]     sum, diff, rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   rem_nx, q_nx;

  assign last = (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mc_q        <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      carry_q     <= 1'b0;
      pofl_q      <= 1'b0;
      qofl_q      <= 1'b0;
      dp_q        <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mc_q        <= mc_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      carry_q     <= carry_d;
      pofl_q      <= pofl_d;
      qofl_q      <= qofl_d;
      dp_q        <= dp_d;
    end
  end

  // Next-state: op dispatch from IDLE, iteration exit on the last count
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (select)
            2'b10:   state_d = S_MUL;
            2'b11:   state_d = S_DIV;
            default: state_d = S_ADDSUB;
          endcase
        end
      end
      S_ADDSUB: state_d = S_DONE;
      S_MUL:    if (last) state_d = S_DONE;
      S_DIV:    if (b_q == '0 || last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: one arithmetic step per cycle, outputs loaded on the DONE edge
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mc_d        = mc_q;
    rem_d       = rem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    carry_d     = carry_q;
    pofl_d      = pofl_q;
    qofl_d      = qofl_q;
    dp_d        = dp_q;

    // full-width intermediates so carry/borrow are never lost
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    acc_step = acc_q + (b_q[0] ? mc_q : '0);
    // restoring step: shift in next dividend bit, subtract if it fits
    rem_sh   = {rem_q, a_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, b_q};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_nx   = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_nx     = {a_q[WIDTH-2:0], rem_ge};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          sel_d = select;
          cnt_d = '0;
          acc_d = '0;
          mc_d  = {{WIDTH{1'b0}}, a};
          rem_d = '0;
        end
      end
      S_ADDSUB: begin
        result_d    = sel_q[0] ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
        carry_d     = sel_q[0] ? (a_q < b_q) : sum[WIDTH];
        remainder_d = '0;
        pofl_d      = 1'b0;
        qofl_d      = 1'b0;
        dp_d        = 2'b00;
      end
      S_MUL: begin
        acc_d = acc_step;
        mc_d  = mc_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          result_d    = acc_step[WIDTH-1:0];
          pofl_d      = |acc_step[2*WIDTH-1:WIDTH];
          carry_d     = 1'b0;
          remainder_d = '0;
          qofl_d      = 1'b0;
          dp_d        = {|acc_step[2*WIDTH-1:WIDTH], 1'b0};
        end
      end
      S_DIV: begin
        if (b_q == '0) begin
          result_d    = '1;
          remainder_d = '0;
          qofl_d      = 1'b1;
          carry_d     = 1'b0;
          pofl_d      = 1'b0;
          dp_d        = 2'b01;
        end else begin
          rem_d = rem_nx;
          a_d   = q_nx;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            result_d    = q_nx;
            remainder_d = rem_nx;
            qofl_d      = 1'b0;
            carry_d     = 1'b0;
            pofl_d      = 1'b0;
            dp_d        = 2'b00;
          end
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign result       = result_q;
  assign remainder    = remainder_q;
  assign carry        = carry_q;
  assign product_ofl  = pofl_q;
  assign quotient_ofl = qofl_q;
  assign dp           = dp_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: driver pushes expected results from an
// arithmetic reference model; a monitor compares every cycle at negedge.
module tb_calc_sequencer;
  localparam int W = 8;
  localparam longint M = (64'd1 << W) - 1;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] select = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result, remainder;
  logic carry, product_ofl, quotient_ofl, busy, done;
  logic [1:0] dp;

  calc_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .select(select), .a(a), .b(b),
    .result(result), .remainder(remainder), .carry(carry),
    .product_ofl(product_ofl), .quotient_ofl(quotient_ofl), .dp(dp),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         c;
    logic         po;
    logic         qo;
    logic [1:0]   dp;
  } outs_t;

  typedef struct {
    outs_t o;
    int    due;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int cyc = 0;
  logic rst_applied = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_applied <= reset;
  end

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reference model straight from the operation definitions
  function automatic exp_t model(input logic [1:0] s, input longint x, input longint y);
    exp_t e;
    longint r;
    e.o = '0;
    e.due = 1;
    case (s)
      2'b00: begin r = x + y; e.o.res = W'(r & M); e.o.c = (r > M); end
      2'b01: begin e.o.res = W'((x - y + M + 1) & M); e.o.c = (x < y); end
      2'b10: begin
        r = x * y;
        e.o.res = W'(r & M);
        e.o.po = (r > M);
        e.o.dp = {e.o.po, 1'b0};
        e.due = W;
      end
      default: begin
        if (y == 0) begin
          e.o.res = W'(M); e.o.qo = 1'b1; e.o.dp = 2'b01;
        end else begin
          e.o.res = W'(x / y); e.o.rem = W'(x % y); e.due = W;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: compare outputs every cycle against the last completed result
  outs_t cur = '0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_applied) begin
      q.delete();
      cur = '0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else begin
      if (q.size() > 0 && cyc > q[0].due) begin
        total++; bad++;
        $display("FAIL done_timeout at cycle %0d: no done, expected by cycle %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done at cycle %0d: done=1, expected 0", cyc);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.due);
          cur = e.o;
        end
        chk("busy_in_done", busy, 1);
      end
      if (prev_done) chk("busy_after_done", busy, 0);
    end
    chk("result", result, cur.res);
    chk("remainder", remainder, cur.rem);
    chk("carry", carry, cur.c);
    chk("product_ofl", product_ofl, cur.po);
    chk("quotient_ofl", quotient_ofl, cur.qo);
    chk("dp", dp, cur.dp);
    prev_done = done;
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout at cycle %0d: busy=%0d, expected 0", cyc, busy);
    end
  endtask

  // Drive one accepted op from a negedge; done expected latency edges after the sampling edge
  task automatic issue(input logic [1:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    wait_idle();
    e = model(s, longint'(x), longint'(y));
    e.due = cyc + 1 + e.due;
    q.push_back(e);
    start = 1'b1; select = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); select = 2'($urandom);
  endtask

  // Start pulse while busy: must be ignored, no expectation pushed
  task automatic pulse_ignored();
    if (busy === 1'b1) begin
      start = 1'b1; select = 2'($urandom); a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 8'd200, 8'd100);
    issue(2'b01, 8'd5, 8'd7);
    issue(2'b01, 8'd9, 8'd4);
    issue(2'b10, 8'd16, 8'd17);
    issue(2'b10, 8'd12, 8'd10);
    issue(2'b11, 8'd100, 8'd7);
    issue(2'b11, 8'd100, 8'd0);
    issue(2'b10, 8'd255, 8'd255);
    issue(2'b11, 8'd255, 8'd1);
    issue(2'b00, 8'd0, 8'd0);
    drain();

    // start during a multiply is ignored, operands scrambled mid-op
    issue(2'b10, 8'd16, 8'd17);
    @(negedge clk);
    pulse_ignored();
    pulse_ignored();
    issue(2'b00, 8'd3, 8'd4);
    drain();

    // reset in the middle of a divide aborts it
    issue(2'b11, 8'd100, 8'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(2'b00, 8'd1, 8'd1);
    drain();

    for (int n = 0; n < 150; n++) begin
      logic [1:0] s;
      logic [W-1:0] x, y;
      s = 2'($urandom_range(0, 3));
      x = W'($urandom_range(0, 255));
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
      issue(s, x, y);
      if ($urandom_range(0, 3) == 0) pulse_ignored();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
